// File: rtl/param_ram.sv
// Parametrised single-port word RAM with req/ack handshake,
// byte-lane writes, configurable read latency and range error.
module param_ram #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                ack_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int BW  = DATA_W / 8;
  localparam int OFF = $clog2(BW);
  localparam int IW  = ADDR_W - OFF;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] hold;
  logic [IW-1:0]     idx;
  logic [AW-1:0]     widx;
  logic              in_range;
  logic              accept;
  logic              rd_ok;
  logic              rd_q;
  logic              err_q;

  generate
    if (OFF > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^addr_i[OFF-1:0];
    end
  endgenerate

  assign idx      = addr_i[ADDR_W-1:OFF];
  assign widx     = idx[AW-1:0];
  assign in_range = 64'(idx) < 64'(DEPTH);
  assign busy_o   = (state == WAIT);
  assign accept   = req_i & ~busy_o & ~rst;
  assign rd_ok    = accept & ~we_i & in_range;
  assign ack_o    = (state == RESP);
  assign err_o    = ack_o & err_q;

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; IDLE and RESP both accept for back-to-back.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_n = WAIT;
            cnt_n   = CW'(LATENCY - 2);
          end else begin
            state_n = RESP;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Byte-lane write into the array at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && we_i && in_range) begin
      for (int j = 0; j < BW; j++) begin
        if (be_i[j]) begin
          mem[widx][8*j +: 8] <= data_i[8*j +: 8];
        end
      end
    end
  end

  // Capture read word and response kind when a transfer is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold  <= '0;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      rd_q  <= ~we_i & in_range;
      err_q <= ~in_range;
      if (rd_ok) begin
        hold <= mem[widx];
      end
    end
  end

  // Output data register: only moves when a good read enters RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
    end else if (LATENCY == 1) begin
      if (rd_ok) begin
        data_o <= mem[widx];
      end
    end else if (state == WAIT && cnt == '0 && rd_q) begin
      data_o <= hold;
    end
  end

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram: a 32-bit LATENCY=1 instance
// and a 64-bit LATENCY=4 instance, both DEPTH=16.
module tb_param_ram;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;
  localparam int DEP   = 16;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic        req_a = 0, we_a = 0;
  logic [31:0] addr_a = 0, wdata_a = 0, rdata_a;
  logic [3:0]  be_a = 0;
  logic        ack_a, err_a, busy_a;

  logic        req_b = 0, we_b = 0;
  logic [31:0] addr_b = 0;
  logic [63:0] wdata_b = 0, rdata_b;
  logic [7:0]  be_b = 0;
  logic        ack_b, err_b, busy_b;

  logic [31:0] ma [DEP];
  logic [63:0] mb [DEP];
  logic [31:0] last_a = 0;
  logic [63:0] last_b = 0;
  exp_t qa [$];
  exp_t qb [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  param_ram #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .LATENCY(LAT_A)
  ) u_a (
    .clk(clk), .rst(rst), .req_i(req_a), .we_i(we_a),
    .addr_i(addr_a), .data_i(wdata_a), .be_i(be_a),
    .data_o(rdata_a), .ack_o(ack_a), .err_o(err_a),
    .busy_o(busy_a)
  );

  param_ram #(
    .DATA_W(64), .ADDR_W(32), .DEPTH(DEP), .LATENCY(LAT_B)
  ) u_b (
    .clk(clk), .rst(rst), .req_i(req_b), .we_i(we_b),
    .addr_i(addr_b), .data_i(wdata_b), .be_i(be_b),
    .data_o(rdata_b), .ack_o(ack_b), .err_o(err_b),
    .busy_o(busy_b)
  );

  task automatic check_eq(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer_a(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  be,
    output int          waited
  );
    exp_t e;
    int   idx;
    @(negedge clk);
    req_a = 1; we_a = we; addr_a = addr;
    wdata_a = data; be_a = be;
    waited = 0;
    while (busy_a && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (busy_a) begin
      check_eq("a_timeout", 64'(busy_a), 0);
      req_a = 0;
      return;
    end
    idx   = int'(addr >> 2);
    e.cyc = cyc + LAT_A;
    e.err = (idx >= DEP);
    if (!e.err) begin
      if (we) begin
        for (int j = 0; j < 4; j++)
          if (be[j]) ma[idx][8*j +: 8] = data[8*j +: 8];
      end else begin
        last_a = ma[idx];
      end
    end
    e.data = 64'(last_a);
    qa.push_back(e);
    @(posedge clk);
    #1 req_a = 0;
  endtask

  task automatic xfer_b(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [63:0] data,
    input  logic [7:0]  be,
    output int          waited
  );
    exp_t e;
    int   idx;
    @(negedge clk);
    req_b = 1; we_b = we; addr_b = addr;
    wdata_b = data; be_b = be;
    waited = 0;
    while (busy_b && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (busy_b) begin
      check_eq("b_timeout", 64'(busy_b), 0);
      req_b = 0;
      return;
    end
    idx   = int'(addr >> 3);
    e.cyc = cyc + LAT_B;
    e.err = (idx >= DEP);
    if (!e.err) begin
      if (we) begin
        for (int j = 0; j < 8; j++)
          if (be[j]) mb[idx][8*j +: 8] = data[8*j +: 8];
      end else begin
        last_b = mb[idx];
      end
    end
    e.data = last_b;
    qb.push_back(e);
    @(posedge clk);
    #1 req_b = 0;
  endtask

  // Response monitor for instance A.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst) begin
      if (ack_a) begin
        if (qa.size() == 0) begin
          check_eq("a_spurious_ack", 64'(ack_a), 0);
        end else begin
          e = qa.pop_front();
          check_eq("a_ack_cyc", 64'(cyc), 64'(e.cyc));
          check_eq("a_err", 64'(err_a), 64'(e.err));
          check_eq("a_data", 64'(rdata_a), e.data);
        end
      end else if (err_a) begin
        check_eq("a_err_noack", 64'(err_a), 0);
      end
    end
  end

  // Response monitor for instance B.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst) begin
      if (ack_b) begin
        if (qb.size() == 0) begin
          check_eq("b_spurious_ack", 64'(ack_b), 0);
        end else begin
          e = qb.pop_front();
          check_eq("b_ack_cyc", 64'(cyc), 64'(e.cyc));
          check_eq("b_err", 64'(err_b), 64'(e.err));
          check_eq("b_data", rdata_b, e.data);
        end
      end else if (err_b) begin
        check_eq("b_err_noack", 64'(err_b), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    check_eq("rst_ack_a", 64'(ack_a), 0);
    check_eq("rst_err_a", 64'(err_a), 0);
    check_eq("rst_busy_a", 64'(busy_a), 0);
    check_eq("rst_data_a", 64'(rdata_a), 0);
    check_eq("rst_ack_b", 64'(ack_b), 0);
    check_eq("rst_err_b", 64'(err_b), 0);
    check_eq("rst_busy_b", 64'(busy_b), 0);
    check_eq("rst_data_b", rdata_b, 0);

    for (int i = 0; i < DEP; i++)
      xfer_a(1, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, w);

    xfer_a(1, 32'h10, 32'hDEAD_BEEF, 4'hF, w);
    xfer_a(0, 32'h10, 32'h0, 4'h0, w);
    check_eq("a_b2b_busy", 64'(w), 0);

    xfer_a(1, 32'h20, 32'h1122_3344, 4'hF, w);
    xfer_a(1, 32'h20, 32'hAABB_CCDD, 4'h5, w);
    xfer_a(0, 32'h22, 32'h0, 4'h0, w);
    xfer_a(1, 32'h24, 32'h5555_5555, 4'h0, w);
    xfer_a(0, 32'h24, 32'h0, 4'h0, w);

    xfer_a(0, 32'h40, 32'h0, 4'h0, w);
    xfer_a(1, 32'h40, 32'hFFFF_FFFF, 4'hF, w);
    xfer_a(1, 32'h7C, 32'hFFFF_FFFF, 4'hF, w);
    for (int i = 0; i < DEP; i++)
      xfer_a(0, 32'(i * 4), 32'h0, 4'h0, w);

    for (int i = 0; i < DEP; i++)
      xfer_b(1, 32'(i * 8), {32'hB0B0_0000 | 32'(i), 32'(~i)}, 8'hFF, w);

    xfer_b(0, 32'h08, 64'h0, 8'h0, w);
    xfer_b(0, 32'h10, 64'h0, 8'h0, w);
    check_eq("b_held_busy", 64'(w), 64'(LAT_B - 1));

    xfer_b(0, 32'h80, 64'h0, 8'h0, w);
    xfer_b(1, 32'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, w);
    for (int i = 0; i < DEP; i++)
      xfer_b(0, 32'(i * 8), 64'h0, 8'h0, w);

    for (int n = 0; n < 60; n++) begin
      xfer_a(1'($urandom_range(0, 1)),
             32'($urandom_range(0, 18) * 4 + $urandom_range(0, 3)),
             $urandom, 4'($urandom_range(0, 15)), w);
    end
    for (int n = 0; n < 40; n++) begin
      xfer_b(1'($urandom_range(0, 1)),
             32'($urandom_range(0, 18) * 8 + $urandom_range(0, 7)),
             {$urandom, $urandom}, 8'($urandom_range(0, 255)), w);
    end

    xfer_b(1, 32'h18, 64'h0123_4567_89AB_CDEF, 8'hFF, w);
    xfer_b(0, 32'h28, 64'h0, 8'h0, w);
    @(negedge clk);
    check_eq("b_busy_pre_rst", 64'(busy_b), 1);
    rst = 1;
    qb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    last_a = 0;
    last_b = 0;
    check_eq("mid_rst_ack_b", 64'(ack_b), 0);
    check_eq("mid_rst_err_b", 64'(err_b), 0);
    check_eq("mid_rst_busy_b", 64'(busy_b), 0);
    check_eq("mid_rst_data_b", rdata_b, 0);
    check_eq("mid_rst_data_a", 64'(rdata_a), 0);
    repeat (10) @(negedge clk);
    xfer_b(0, 32'h18, 64'h0, 8'h0, w);

    repeat (10) @(negedge clk);
    check_eq("a_q_empty", 64'(qa.size()), 0);
    check_eq("b_q_empty", 64'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_ram.md
# param_ram

Parametrised single-port word RAM for the core's memory bus: configurable data width, depth and read latency, with byte-lane write enables, a req/ack handshake with back-pressure, and an out-of-range error response. It replaces fixed-width, zero-latency data memories wherever the bus must tolerate multi-cycle responses. A single FSM sequences each transfer; one transfer is outstanding at a time.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, 8..64
- ADDR_W, 32, byte-address width
- DEPTH, 4096, number of DATA_W words
- LATENCY, 1, cycles from acceptance to ack; 1..8
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  transfer request, level; held with inputs stable until accepted
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
- data_i  in  DATA_W  write data
- be_i  in  DATA_W/8  byte-lane write enables
- data_o  out  DATA_W  read data, valid while ack_o=1 for a successful read
- ack_o  out  1  one-cycle transfer-complete pulse
- err_o  out  1  qualifies ack_o: address out of range
- busy_o  out  1  request will not be accepted this cycle

## Operation
- Word index idx = addr_i[ADDR_W-1 : log2(DATA_W/8)]; out of range when idx >= DEPTH.
- Acceptance: at a rising edge with req_i=1, busy_o=0, and rst=0.
- FSM states IDLE, WAIT, RESP; state register resets to IDLE.
  - IDLE/RESP + acceptance -> WAIT if LATENCY>1, load counter with LATENCY-2; -> RESP if LATENCY=1.
  - IDLE/RESP without acceptance -> IDLE.
  - WAIT: counter decrements each edge; at 0 -> RESP.
- busy_o = (state == WAIT); acceptance is allowed in IDLE and RESP (back-to-back).
- Write, in range: at the acceptance edge, for each j with be_i[j]=1, bits [8j+7:8j] of word idx <= data_i bits [8j+7:8j]. Other lanes unchanged. be_i=0 still acks.
- Read, in range: word idx sampled at the acceptance edge into a holding register and presented on data_o in RESP.
- Out of range: no array access. In RESP, ack_o=1 and err_o=1.
- ack_o=1 exactly while state==RESP. err_o is valid only with ack_o and is 0 otherwise.
- data_o changes only on a successful read response and holds its value otherwise, including through write and error acks.
- Memory array is not cleared by rst; contents are undefined at power-up.

## Timing
- Reset values: ack_o=0, err_o=0, busy_o=0, data_o=0, state=IDLE, counter=0.
- Request accepted at edge k: ack_o is high for exactly the one cycle following edge k+LATENCY-1.
- With LATENCY=1, one transfer per cycle is sustained; with LATENCY=L, one transfer every L cycles.
- Read after write to the same word, accepted in consecutive transfers: the read returns the new data.
- rst asserted during WAIT or RESP: the transfer is abandoned and no ack is issued. A write accepted before the rst edge remains committed.
- req_i while busy_o=1: ignored with no side effect. The requester holds it.

## Test plan
- Reset: assert rst 2 cycles mid-read with LATENCY=3 -> ack_o, err_o, busy_o, data_o all 0; no ack follows release.
- LATENCY=1, DATA_W=32: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> ack in each cycle following its acceptance edge; read data_o=0xDEADBEEF; busy_o stays 0.
- Byte lanes: write 0x11223344 to 0x20 with be_i=4'b1111, then 0xAABBCCDD with be_i=4'b0101 -> read returns 0x11BB33DD.
- LATENCY=4: read held on req_i -> busy_o=1 for 3 cycles; ack_o one cycle later, 4 cycles after acceptance; a second req_i held during busy is accepted at the ack-cycle edge.
- DEPTH=16: read 0x40 (idx 16) -> ack_o=1, err_o=1, data_o unchanged. Write 0x40 -> err ack; no in-range word modified (readback of idx 0..15 unchanged).
- Parameter sweep DATA_W=8/64, LATENCY=1/8: random reads and writes vs reference model -> data and ack-timing match.
